taus_multi: RTL and testbench

Parametrised multi-channel Tausworthe generator, the next generation of the single-channel taus113 RNG. It supports CHANNELS independent generator lanes and a build-time choice of combined Tausworthe variant (LFSR113 or taus88). Every lane is seeded internally from a single 32-bit seed through an LCG expansion, and a programmable warm-up follows. Output uses a valid/ready stream, so stochastic consumers downstream can apply backpressure without losing or repeating samples.

---
 rtl/taus_multi_if.sv | 30 +++
 rtl/taus_multi.sv | 157 +++++++++++++++
 tb/tb_taus_multi.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/taus_multi_if.sv
// Control and sample-stream bundle for taus_multi. The consumer side drives the seed,
// the reseed request and rnd_ready. The generator side drives status and samples.
interface taus_multi_if #(
  parameter int unsigned CHANNELS = 4
);
  logic [31:0]            seed;
  logic                   re_seed;
  logic                   busy;
  logic                   rnd_valid;
  logic                   rnd_ready;
  logic [32*CHANNELS-1:0] rnd_data;

  modport master (
    output seed,
    output re_seed,
    output rnd_ready,
    input  busy,
    input  rnd_valid,
    input  rnd_data
  );

  modport slave (
    input  seed,
    input  re_seed,
    input  rnd_ready,
    output busy,
    output rnd_valid,
    output rnd_data
  );
endinterface

// File: rtl/taus_multi.sv
// Multi-lane combined Tausworthe RNG (LFSR113 or taus88). Every lane is filled one word per
// cycle from an LCG expansion of a 32-bit seed. A warm-up follows, then the lanes serve a
// valid/ready stream.
module taus_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned GEN          = 113,
  parameter int unsigned WARMUP       = 10,
  parameter logic [31:0] DEFAULT_SEED = 32'h1234_5678
) (
  input logic         clk,
  input logic         rst,
  taus_multi_if.slave bus
);

  localparam int unsigned W        = (GEN == 88) ? 3 : 4;
  localparam int unsigned LaneW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [LaneW-1:0] LaneLast = LaneW'(CHANNELS - 1);
  localparam logic [1:0]  CompLast = 2'(W - 1);
  localparam logic [7:0]  WarmLast = 8'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [31:0] LcgMul   = 32'd69069;

  typedef enum logic [1:0] {StSeed, StWarm, StRun} state_e;
  typedef logic [W-1:0][31:0] lane_t;

  state_e                  state_q, state_d;
  lane_t [CHANNELS-1:0]    z_q, z_d;
  logic [31:0]             lcg_q, lcg_d;
  logic [LaneW-1:0]        lane_q, lane_d;
  logic [1:0]              comp_q, comp_d;
  logic [7:0]              warm_q, warm_d;
  logic [32*CHANNELS-1:0]  rnd_data;

  // A word below its component minimum would leave that component stuck, so it is lifted.
  function automatic logic [31:0] comp_min(input logic [1:0] k);
    logic [31:0] m;
    unique case (k)
      2'd0:    m = 32'd2;
      2'd1:    m = 32'd8;
      2'd2:    m = 32'd16;
      default: m = 32'd128;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] comp_step(input logic [1:0] k, input logic [31:0] z);
    logic [31:0] r;
    if (GEN == 88) begin
      unique case (k)
        2'd0:    r = ((z & 32'hFFFF_FFFE) << 12) ^ (((z << 13) ^ z) >> 19);
        2'd1:    r = ((z & 32'hFFFF_FFF8) << 4) ^ (((z << 2) ^ z) >> 25);
        default: r = ((z & 32'hFFFF_FFF0) << 17) ^ (((z << 3) ^ z) >> 11);
      endcase
    end else begin
      unique case (k)
        2'd0:    r = ((z & 32'hFFFF_FFFE) << 18) ^ (((z << 6) ^ z) >> 13);
        2'd1:    r = ((z & 32'hFFFF_FFF8) << 2) ^ (((z << 2) ^ z) >> 27);
        2'd2:    r = ((z & 32'hFFFF_FFF0) << 7) ^ (((z << 13) ^ z) >> 21);
        default: r = ((z & 32'hFFFF_FF80) << 13) ^ (((z << 3) ^ z) >> 12);
      endcase
    end
    return r;
  endfunction

  function automatic lane_t lane_step(input lane_t l);
    lane_t r;
    for (int unsigned k = 0; k < W; k++) begin
      r[k] = comp_step(2'(k), l[k]);
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    lcg_d   = lcg_q;
    lane_d  = lane_q;
    comp_d  = comp_q;
    warm_d  = warm_q;
    // A reseed overrides everything, including a handshake on the same edge.
    if (bus.re_seed) begin
      state_d = StSeed;
      z_d     = '0;
      lcg_d   = bus.seed;
      lane_d  = '0;
      comp_d  = '0;
      warm_d  = '0;
    end else begin
      unique case (state_q)
        StSeed: begin
          z_d[lane_q][comp_q] = (lcg_q < comp_min(comp_q)) ? lcg_q + comp_min(comp_q) : lcg_q;
          lcg_d = lcg_q * LcgMul + 32'd1;
          if (comp_q == CompLast) begin
            comp_d = '0;
            if (lane_q == LaneLast) begin
              lane_d  = '0;
              state_d = (WARMUP == 0) ? StRun : StWarm;
            end else begin
              lane_d = lane_q + 1'b1;
            end
          end else begin
            comp_d = comp_q + 2'd1;
          end
        end
        StWarm: begin
          for (int unsigned c = 0; c < CHANNELS; c++) begin
            z_d[c] = lane_step(z_q[c]);
          end
          warm_d = warm_q + 8'd1;
          if (warm_q == WarmLast) begin
            warm_d  = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (bus.rnd_ready) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
              z_d[c] = lane_step(z_q[c]);
            end
          end
        end
        default: state_d = StSeed;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StSeed;
      z_q     <= '0;
      lcg_q   <= DEFAULT_SEED;
      lane_q  <= '0;
      comp_q  <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      lcg_q   <= lcg_d;
      lane_q  <= lane_d;
      comp_q  <= comp_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    rnd_data = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned k = 0; k < W; k++) begin
        rnd_data[32*c +: 32] = rnd_data[32*c +: 32] ^ z_q[c][k];
      end
    end
  end

  assign bus.rnd_data  = rnd_data;
  assign bus.rnd_valid = (state_q == StRun);
  assign bus.busy      = (state_q != StRun);

endmodule

// File: tb/tb_taus_multi.sv
// Bench for taus_multi: three differently-built instances, checked every cycle against a
// seed-expansion / step-count reference model, plus literal and latency spot checks.
module tb_taus_multi;
  localparam logic [31:0] DefSeed = 32'h1234_5678;
  localparam int PCh  [3] = '{4, 2, 3};
  localparam int PGen [3] = '{113, 113, 88};
  localparam int PWu  [3] = '{10, 0, 5};

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  taus_multi_if #(.CHANNELS(4)) bus_a ();
  taus_multi_if #(.CHANNELS(2)) bus_b ();
  taus_multi_if #(.CHANNELS(3)) bus_c ();

  taus_multi #(.CHANNELS(4), .GEN(113), .WARMUP(10), .DEFAULT_SEED(DefSeed)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  taus_multi #(.CHANNELS(2), .GEN(113), .WARMUP(0), .DEFAULT_SEED(DefSeed)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));
  taus_multi #(.CHANNELS(3), .GEN(88), .WARMUP(5), .DEFAULT_SEED(DefSeed)) dut_c (
    .clk(clk), .rst(rst), .bus(bus_c));

  // ---------------- reference arithmetic ----------------
  function automatic int ww_of(int i);
    return (PGen[i] == 113) ? 4 : 3;
  endfunction

  function automatic int cw_of(int i);
    return PCh[i] * ww_of(i);
  endfunction

  function automatic logic [31:0] ref_fix(int k, logic [31:0] w);
    logic [31:0] m;
    case (k)
      0: m = 32'd2;
      1: m = 32'd8;
      2: m = 32'd16;
      default: m = 32'd128;
    endcase
    return (w < m) ? w + m : w;
  endfunction

  function automatic logic [31:0] ref_step(int gen, int k, logic [31:0] z);
    logic [31:0] r;
    if (gen == 113) begin
      case (k)
        0: r = ((z & 32'hFFFF_FFFE) << 18) ^ (((z << 6) ^ z) >> 13);
        1: r = ((z & 32'hFFFF_FFF8) << 2) ^ (((z << 2) ^ z) >> 27);
        2: r = ((z & 32'hFFFF_FFF0) << 7) ^ (((z << 13) ^ z) >> 21);
        default: r = ((z & 32'hFFFF_FF80) << 13) ^ (((z << 3) ^ z) >> 12);
      endcase
    end else begin
      case (k)
        0: r = ((z & 32'hFFFF_FFFE) << 12) ^ (((z << 13) ^ z) >> 19);
        1: r = ((z & 32'hFFFF_FFF8) << 4) ^ (((z << 2) ^ z) >> 25);
        default: r = ((z & 32'hFFFF_FFF0) << 17) ^ (((z << 3) ^ z) >> 11);
      endcase
    end
    return r;
  endfunction

  // Lane c output after seeding and nsteps steps, computed from scratch.
  function automatic logic [31:0] ref_out(int gen, int ch, int nsteps, logic [31:0] seed, int c);
    logic [31:0] z [16][4];
    int          ww = (gen == 113) ? 4 : 3;
    logic [31:0] w = seed;
    logic [31:0] x = '0;
    for (int k = 0; k < ch * ww; k++) begin
      z[k / ww][k % ww] = ref_fix(k % ww, w);
      w = w * 32'd69069 + 32'd1;
    end
    for (int s = 0; s < nsteps; s++)
      for (int k = 0; k < ww; k++) z[c][k] = ref_step(gen, k, z[c][k]);
    for (int k = 0; k < ww; k++) x = x ^ z[c][k];
    return x;
  endfunction

  // ---------------- behavioural model: edges since the last seed event ----------------
  logic [31:0] m_base [3][16][4];
  logic [31:0] m_cur  [3][16][4];
  int          m_t    [3];
  bit          m_live [3] = '{0, 0, 0};

  task automatic model_edge(int i, logic rs, logic [31:0] sd, logic rdy);
    int          ww = ww_of(i);
    int          cw = cw_of(i);
    logic [31:0] w;
    if (rst === 1'b1 || rs === 1'b1) begin
      w = (rst === 1'b1) ? DefSeed : sd;
      for (int k = 0; k < cw; k++) begin
        m_base[i][k / ww][k % ww] = ref_fix(k % ww, w);
        m_cur[i][k / ww][k % ww]  = ref_fix(k % ww, w);
        w = w * 32'd69069 + 32'd1;
      end
      m_t[i]    = 0;
      m_live[i] = 1'b1;
    end else if (m_live[i]) begin
      if (m_t[i] < cw + PWu[i]) begin
        if (m_t[i] >= cw)
          for (int c = 0; c < PCh[i]; c++)
            for (int k = 0; k < ww; k++) m_cur[i][c][k] = ref_step(PGen[i], k, m_cur[i][c][k]);
        m_t[i]++;
      end else if (rdy === 1'b1) begin
        for (int c = 0; c < PCh[i]; c++)
          for (int k = 0; k < ww; k++) m_cur[i][c][k] = ref_step(PGen[i], k, m_cur[i][c][k]);
      end
    end
  endtask

  function automatic logic [31:0] m_lane(int i, int c);
    int          ww = ww_of(i);
    logic [31:0] x = '0;
    for (int k = 0; k < ww; k++) begin
      if (m_t[i] < cw_of(i)) x = x ^ ((c * ww + k < m_t[i]) ? m_base[i][c][k] : 32'd0);
      else x = x ^ m_cur[i][c][k];
    end
    return x;
  endfunction

  always @(posedge clk) begin
    model_edge(0, bus_a.re_seed, bus_a.seed, bus_a.rnd_ready);
    model_edge(1, bus_b.re_seed, bus_b.seed, bus_b.rnd_ready);
    model_edge(2, bus_c.re_seed, bus_c.seed, bus_c.rnd_ready);
  end

  // ---------------- DUT accessors ----------------
  function automatic logic [31:0] dut_lane(int i, int c);
    case (i)
      0: return bus_a.rnd_data[32*c +: 32];
      1: return bus_b.rnd_data[32*c +: 32];
      default: return bus_c.rnd_data[32*c +: 32];
    endcase
  endfunction

  function automatic logic dut_valid(int i);
    case (i)
      0: return bus_a.rnd_valid;
      1: return bus_b.rnd_valid;
      default: return bus_c.rnd_valid;
    endcase
  endfunction

  function automatic logic dut_busy(int i);
    case (i)
      0: return bus_a.busy;
      1: return bus_b.busy;
      default: return bus_c.busy;
    endcase
  endfunction

  // Single compare process: every instance, every cycle, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_live[i]) begin
        logic ev;
        bit   ok;
        int   ml;
        ev = (m_t[i] >= cw_of(i) + PWu[i]);
        ok = (dut_valid(i) === ev) && (dut_busy(i) === !ev);
        ml = 0;
        for (int c = PCh[i] - 1; c >= 0; c--) begin
          if (dut_lane(i, c) !== m_lane(i, c)) begin
            ok = 1'b0;
            ml = c;
          end
        end
        checks++;
        if (!ok) begin
          failures++;
          $display("FAIL stream_cmp inst=%0d t=%0d valid=%b exp_valid=%b busy=%b lane%0d got=%h exp=%h",
                   i, m_t[i], dut_valid(i), ev, dut_busy(i), ml, dut_lane(i, ml), m_lane(i, ml));
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called right after the edge that sampled the seed event.
  task automatic latency(int i, string name, int exp_n);
    int n = 0;
    bit busy_bad = 1'b0;
    while (dut_valid(i) !== 1'b1 && n < 100) begin
      if (dut_busy(i) !== 1'b1) busy_bad = 1'b1;
      tick();
      n++;
    end
    check({name, "_edges"}, 32'(n), 32'(exp_n));
    check({name, "_busy_hi"}, 32'(busy_bad), 32'd0);
    check({name, "_busy_fall"}, 32'(dut_busy(i)), 32'd0);
  endtask

  task automatic lanes_distinct(int i, string name);
    bit dup = 1'b0;
    for (int a = 0; a < PCh[i]; a++)
      for (int b = a + 1; b < PCh[i]; b++)
        if (dut_lane(i, a) === dut_lane(i, b)) dup = 1'b1;
    check(name, 32'(dup), 32'd0);
  endtask

  task automatic reseed(int i, logic [31:0] s);
    case (i)
      0: begin bus_a.seed = s; bus_a.re_seed = 1'b1; tick(); bus_a.re_seed = 1'b0; end
      1: begin bus_b.seed = s; bus_b.re_seed = 1'b1; tick(); bus_b.re_seed = 1'b0; end
      default: begin bus_c.seed = s; bus_c.re_seed = 1'b1; tick(); bus_c.re_seed = 1'b0; end
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] s1;
    bit          vbad;
    rst = 1'b1;
    bus_a.seed = '0; bus_a.re_seed = 1'b0; bus_a.rnd_ready = 1'b0;
    bus_b.seed = '0; bus_b.re_seed = 1'b0; bus_b.rnd_ready = 1'b0;
    bus_c.seed = '0; bus_c.re_seed = 1'b0; bus_c.rnd_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("reset_valid", 32'(bus_a.rnd_valid), 32'd0);
    check("reset_busy", 32'(bus_a.busy), 32'd1);
    check("reset_data", bus_a.rnd_data[31:0], 32'd0);
    latency(0, "rst_lat", 26);
    check("rst_lane0", dut_lane(0, 0), ref_out(113, 4, 10, DefSeed, 0));

    reseed(0, 32'hDEAD_BEEF);
    latency(0, "reseed_lat", 26);
    check("deadbeef_lane3", dut_lane(0, 3), ref_out(113, 4, 10, 32'hDEAD_BEEF, 3));

    // Random backpressure; the compare process tracks holds and accepted steps.
    repeat (800) begin
      bus_a.rnd_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Reseed mid-SEED, again mid-WARM, then a final seed; valid must never rise in between.
    s1 = $urandom();
    bus_a.rnd_ready = 1'b1;
    reseed(0, s1);
    vbad = 1'b0;
    repeat (4) begin tick(); if (bus_a.rnd_valid !== 1'b0) vbad = 1'b1; end
    reseed(0, s1 ^ 32'h5A5A_5A5A);
    repeat (19) begin tick(); if (bus_a.rnd_valid !== 1'b0) vbad = 1'b1; end
    reseed(0, 32'h0BAD_F00D);
    check("midop_valid_low", 32'(vbad), 32'd0);
    latency(0, "midop_lat", 26);
    for (int c = 0; c < 4; c++)
      check("midop_lane", dut_lane(0, c), ref_out(113, 4, 10, 32'h0BAD_F00D, c));

    // rst and re_seed together: the default seed wins.
    bus_a.rnd_ready = 1'b0;
    rst = 1'b1;
    bus_a.seed = 32'hCAFE_BABE;
    bus_a.re_seed = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.re_seed = 1'b0;
    latency(0, "rst_prio_lat", 26);
    check("rst_prio_lane0", dut_lane(0, 0), ref_out(113, 4, 10, DefSeed, 0));
    check("rst_prio_lane2", dut_lane(0, 2), ref_out(113, 4, 10, DefSeed, 2));

    // re_seed with a live handshake: no step, standard latency.
    bus_a.rnd_ready = 1'b1;
    reseed(0, 32'hCAFE_BABE);
    check("hs_reseed_valid", 32'(bus_a.rnd_valid), 32'd0);
    latency(0, "hs_reseed_lat", 26);
    check("hs_reseed_lane1", dut_lane(0, 1), ref_out(113, 4, 10, 32'hCAFE_BABE, 1));
    repeat (1000) tick();
    lanes_distinct(0, "a_distinct");
    bus_a.rnd_ready = 1'b0;

    // WARMUP=0 instance, seed 0: literal lane 0 values.
    reseed(1, 32'd0);
    latency(1, "b_lat", 8);
    check("b_lane0_literal", dut_lane(1, 0), 32'h1C58_8E32);
    check("model_z1", m_base[1][0][0], 32'd2);
    check("model_z2", m_base[1][0][1], 32'd9);
    check("model_z3", m_base[1][0][2], 32'd69070);
    check("model_z4", m_base[1][0][3], 32'd475628535);
    bus_b.rnd_ready = 1'b1;
    repeat (200) tick();
    bus_b.rnd_ready = 1'b0;

    // taus88 instance.
    reseed(2, 32'hDEAD_BEEF);
    latency(2, "c_lat", 14);
    check("c_lane2", dut_lane(2, 2), ref_out(88, 3, 5, 32'hDEAD_BEEF, 2));
    bus_c.rnd_ready = 1'b1;
    repeat (1000) tick();
    lanes_distinct(2, "c_distinct");
    reseed(2, 32'hCAFE_BABE);
    latency(2, "c_lat2", 14);
    check("c_lane0", dut_lane(2, 0), ref_out(88, 3, 5, 32'hCAFE_BABE, 0));
    repeat (1000) begin
      bus_c.rnd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    lanes_distinct(2, "c_distinct2");

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
